// File: rtl/cpu_decode_pkg.sv
// -----------------------------------------------------------------------------
// cpu_decode_pkg
//   Shared definitions for the decode stage: RV32 base opcodes, the IMM_SELECT
//   encodings consumed by immediate_generation_unit, the canonical NOP, the
//   decode-stage FSM state encodings and the decoder result bundle.
// -----------------------------------------------------------------------------
package cpu_decode_pkg;

    localparam int XLEN = 32;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Immediate-format select codes
    localparam logic [2:0] IMM_SEL_U    = 3'b000;
    localparam logic [2:0] IMM_SEL_J    = 3'b001;
    localparam logic [2:0] IMM_SEL_I    = 3'b010;
    localparam logic [2:0] IMM_SEL_B    = 3'b011;
    localparam logic [2:0] IMM_SEL_S    = 3'b100;
    localparam logic [2:0] IMM_SEL_NONE = 3'b111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    // Decode-stage FSM states
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       illegal;
    } dec_info_t;

endpackage

// File: rtl/imm_select_decoder.sv
// -----------------------------------------------------------------------------
// imm_select_decoder
//   Purely combinational opcode classifier.
//   Ports:
//     i_opcode   in  7   instr[6:0]
//     o_info     out     {imm_sel, uses_rs1, uses_rs2, is_load, illegal}
//   rs1 is a source for every opcode except U/J formats; rs2 only for
//   R/S/B formats. Any opcode outside the table (which also covers
//   instr[1:0] != 2'b11, since every table entry ends in 2'b11) is illegal and
//   selects IMM_SEL_NONE.
// -----------------------------------------------------------------------------
module imm_select_decoder
    import cpu_decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    output dec_info_t  o_info
);

    always_comb begin
        o_info          = '0;
        o_info.imm_sel  = IMM_SEL_NONE;
        o_info.uses_rs1 = 1'b1;
        case (i_opcode)
            OPC_LUI, OPC_AUIPC: begin
                o_info.imm_sel  = IMM_SEL_U;
                o_info.uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                o_info.imm_sel  = IMM_SEL_J;
                o_info.uses_rs1 = 1'b0;
            end
            OPC_OP_IMM, OPC_JALR: begin
                o_info.imm_sel  = IMM_SEL_I;
            end
            OPC_LOAD: begin
                o_info.imm_sel  = IMM_SEL_I;
                o_info.is_load  = 1'b1;
            end
            OPC_BRANCH: begin
                o_info.imm_sel  = IMM_SEL_B;
                o_info.uses_rs2 = 1'b1;
            end
            OPC_STORE: begin
                o_info.imm_sel  = IMM_SEL_S;
                o_info.uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                o_info.uses_rs2 = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                o_info.imm_sel  = IMM_SEL_NONE;
            end
            default: begin
                o_info.illegal  = 1'b1;
            end
        endcase
        if (i_opcode[1:0] != 2'b11) begin
            o_info.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_controller.sv
// -----------------------------------------------------------------------------
// decode_issue_controller
//   Decode-stage sequencer: one-entry IF/ID register with valid/ready on both
//   sides, IMM_SELECT decode, single-bubble load-use interlock, branch flush.
//
//   Handshake: a word moves across an interface in a cycle where the producer's
//   valid and the consumer's ready are both high at the rising edge. Valid must
//   not depend on ready; ID_READY is combinational from state, FLUSH, EX_READY.
//
//   Ports:
//     CLK, RESET_N          clock (rising), async active-low reset
//     IF_VALID/IF_INSTRUCTION/IF_PC/ID_READY   fetch side
//     FLUSH                 kill held instruction (highest priority)
//     EX_READY/ID_VALID/ID_INSTRUCTION/ID_PC   execute side
//     IMM_SELECT            immediate format of held instruction (NONE if invalid)
//     ID_RS1/ID_RS2/ID_RD   register fields of held instruction
//     LOAD_USE_STALL        bubble cycle in progress
//     ILLEGAL_INSTR         only with DECODE_ILLEGAL_TRAP_EN defined
//     DBG_STATE             FSM state (EMPTY=0, FULL=1, BUBBLE=2)
//
//   Optional feature macro: DECODE_ILLEGAL_TRAP_EN
// -----------------------------------------------------------------------------
module decode_issue_controller
    import cpu_decode_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IF_VALID,
    input  logic [31:0]     IF_INSTRUCTION,
    input  logic [31:0]     IF_PC,
    output logic            ID_READY,
    input  logic            FLUSH,
    input  logic            EX_READY,
    output logic            ID_VALID,
    output logic [31:0]     ID_INSTRUCTION,
    output logic [31:0]     ID_PC,
    output logic [2:0]      IMM_SELECT,
    output logic [4:0]      ID_RS1,
    output logic [4:0]      ID_RS2,
    output logic [4:0]      ID_RD,
    output logic            LOAD_USE_STALL,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic            ILLEGAL_INSTR,
`endif
    output logic [1:0]      DBG_STATE
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [31:0]     r_instr;
    logic [31:0]     r_pc;
    logic            r_load_flag;
    logic [4:0]      r_last_rd;

    dec_info_t       w_held;
    dec_info_t       w_incoming;

    logic            w_id_valid;
    logic            w_issue;
    logic            w_capture;
    logic            w_accept_ok;
    logic            w_nxt_load_flag;
    logic [4:0]      w_nxt_last_rd;
    logic [4:0]      w_if_rs1;
    logic [4:0]      w_if_rs2;
    logic            w_cap_hazard;

    imm_select_decoder u_dec_held (
        .i_opcode (r_instr[6:0]),
        .o_info   (w_held)
    );

    // Second decoder classifies the word being captured so the load-use check
    // can be resolved on the capture edge.
    imm_select_decoder u_dec_incoming (
        .i_opcode (IF_INSTRUCTION[6:0]),
        .o_info   (w_incoming)
    );

    assign w_id_valid = (r_state == ST_FULL);
    assign w_issue    = w_id_valid & EX_READY & ~FLUSH;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_trap_lock;
    logic w_unused_dec;

    // After an illegal word is seen, fetch is held off until a flush redirects.
    assign w_accept_ok   = ~r_trap_lock & ~(w_id_valid & w_held.illegal);
    assign ILLEGAL_INSTR = w_id_valid & w_held.illegal;
    assign w_unused_dec  = ^{w_incoming.imm_sel, w_incoming.is_load, w_incoming.illegal};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_trap_lock <= 1'b0;
        end else if (FLUSH) begin
            r_trap_lock <= 1'b0;
        end else if (w_issue && w_held.illegal) begin
            r_trap_lock <= 1'b1;
        end
    end
`else
    logic w_unused_dec;

    assign w_accept_ok  = 1'b1;
    assign w_unused_dec = ^{w_incoming.imm_sel, w_incoming.is_load, w_incoming.illegal,
                            w_held.illegal};
`endif

    // The hazard is detected when the dependent word is captured, which sends
    // the FSM to BUBBLE rather than FULL. Hence a FULL instruction is never
    // hazardous and ready needs no hazard term here.
    assign ID_READY  = ~FLUSH & w_accept_ok &
                       ((r_state == ST_EMPTY) | ((r_state == ST_FULL) & EX_READY));
    assign w_capture = IF_VALID & ID_READY;

    // Bookkeeping as it will stand after this edge: if the held word issues
    // now, the incoming word is checked against it.
    assign w_nxt_load_flag = w_issue ? w_held.is_load : r_load_flag;
    assign w_nxt_last_rd   = w_issue ? r_instr[11:7]  : r_last_rd;
    assign w_if_rs1        = IF_INSTRUCTION[19:15];
    assign w_if_rs2        = IF_INSTRUCTION[24:20];
    assign w_cap_hazard    = w_nxt_load_flag & (w_nxt_last_rd != 5'd0) &
                             ((w_incoming.uses_rs1 & (w_if_rs1 == w_nxt_last_rd)) |
                              (w_incoming.uses_rs2 & (w_if_rs2 == w_nxt_last_rd)));

    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_capture) begin
                        w_state_nxt = w_cap_hazard ? ST_BUBBLE : ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (EX_READY) begin
                        if (w_capture) begin
                            w_state_nxt = w_cap_hazard ? ST_BUBBLE : ST_FULL;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                end
                ST_BUBBLE: begin
                    w_state_nxt = ST_FULL;
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (w_capture) begin
            r_instr <= IF_INSTRUCTION;
            r_pc    <= IF_PC;
        end
    end

    // Issue bookkeeping. A bubble sends nothing to EX, so the load that caused
    // it no longer sits directly ahead of the held instruction.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_load_flag <= 1'b0;
            r_last_rd   <= '0;
        end else if (FLUSH) begin
            r_load_flag <= 1'b0;
        end else if (r_state == ST_BUBBLE) begin
            r_load_flag <= 1'b0;
        end else if (w_issue) begin
            r_load_flag <= w_held.is_load;
            r_last_rd   <= r_instr[11:7];
        end
    end

    assign ID_VALID       = w_id_valid;
    assign ID_INSTRUCTION = w_id_valid ? r_instr : NOP_INSTR;
    assign ID_PC          = r_pc;
    assign IMM_SELECT     = w_id_valid ? w_held.imm_sel : IMM_SEL_NONE;
    assign ID_RS1         = r_instr[19:15];
    assign ID_RS2         = r_instr[24:20];
    assign ID_RD          = r_instr[11:7];
    assign LOAD_USE_STALL = (r_state == ST_BUBBLE);
    assign DBG_STATE      = r_state;

endmodule
